// File: rtl/ttc_pkg.sv
// Shared TTC link definitions: frame width, sync and idle
// patterns, and the transmitter state encoding.
package ttc_pkg;

    localparam int FRAME_W = 16;

    localparam logic [FRAME_W-1:0] SYNC_PATTERN = 16'h817E;
    localparam logic [FRAME_W-1:0] NOOP_PATTERN = 16'h6969;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } tx_state_t;

endpackage

// File: rtl/ttc_frame_shifter.sv
// MSB-first frame serializer: parallel load on strobe,
// shift left one bit per clk160 otherwise.
module ttc_frame_shifter
    import ttc_pkg::*;
(
    input  logic               clk160,
    input  logic               rst,
    input  logic               load,
    input  logic [FRAME_W-1:0] frame,
    output logic               msb
);

    logic [FRAME_W-1:0] sr;

    // load a new frame or move the next bit into the MSB
    always_ff @(posedge clk160) begin
        if (rst) begin
            sr <= '0;
        end else if (load) begin
            sr <= frame;
        end else begin
            sr <= {sr[FRAME_W-2:0], 1'b0};
        end
    end

    assign msb = sr[FRAME_W-1];

endmodule

// File: rtl/ttc_cmd_tx.sv
// TTC command link transmitter: INIT syncs, then data/NOOP
// frames with a forced sync slot. Stats: TTC_TX_STATS_EN.
module ttc_cmd_tx
    import ttc_pkg::*;
#(
    parameter int SYNC_INTERVAL = 32,
    parameter int INIT_SYNCS    = 4
) (
    input  logic               clk160,
    input  logic               rst,
    input  logic [FRAME_W-1:0] data_in,
    input  logic               word_valid,
    output logic               word_ready,
    output logic               dataout,
    output logic               frame_start
`ifdef TTC_TX_STATS_EN
    ,
    output logic [31:0]        frames_data,
    output logic [31:0]        frames_sync
`endif
);

    localparam int BC_W = $clog2(FRAME_W);
    localparam int SC_W = (SYNC_INTERVAL > 2) ? $clog2(SYNC_INTERVAL) : 1;
    localparam int IC_W = $clog2(INIT_SYNCS + 1);

    localparam logic [BC_W-1:0] BIT_TOP   = BC_W'(FRAME_W - 1);
    localparam logic [SC_W-1:0] SYNC_LAST = SC_W'(SYNC_INTERVAL - 1);
    localparam logic [IC_W-1:0] INIT_LAST = IC_W'(INIT_SYNCS - 1);

    tx_state_t          state;
    logic [BC_W-1:0]    bit_cnt;
    logic [SC_W-1:0]    sync_cnt;
    logic [IC_W-1:0]    init_cnt;
    logic               first;
    logic               load;
    logic               force_sync;
    logic [FRAME_W-1:0] frame;

    assign load       = first || (bit_cnt == '0);
    assign force_sync = (state == INIT) || (sync_cnt == SYNC_LAST);

    // a slot is offered only at a RUN load that is not owed to a sync
    assign word_ready = !rst && (state == RUN) && load &&
                        (sync_cnt != SYNC_LAST);

    // pick the frame for the next slot
    always_comb begin
        frame = NOOP_PATTERN;
        if (force_sync) begin
            frame = SYNC_PATTERN;
        end else if (word_valid) begin
            frame = data_in;
        end
    end

    // bit timing, sync spacing and INIT->RUN sequencing
    always_ff @(posedge clk160) begin
        if (rst) begin
            state       <= INIT;
            bit_cnt     <= BIT_TOP;
            sync_cnt    <= '0;
            init_cnt    <= '0;
            first       <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            first       <= 1'b0;
            frame_start <= load;
            if (load) begin
                bit_cnt <= BIT_TOP;
                if (force_sync) begin
                    sync_cnt <= '0;
                end else begin
                    sync_cnt <= sync_cnt + 1'b1;
                end
                if (state == INIT) begin
                    init_cnt <= init_cnt + 1'b1;
                    if (init_cnt == INIT_LAST) begin
                        state <= RUN;
                    end
                end
            end else begin
                bit_cnt <= bit_cnt - 1'b1;
            end
        end
    end

    ttc_frame_shifter u_shifter (
        .clk160 (clk160),
        .rst    (rst),
        .load   (load),
        .frame  (frame),
        .msb    (dataout)
    );

`ifdef TTC_TX_STATS_EN
    // count loaded frames by type; wraps naturally at 2^32
    always_ff @(posedge clk160) begin
        if (rst) begin
            frames_data <= '0;
            frames_sync <= '0;
        end else if (load) begin
            if (force_sync) begin
                frames_sync <= frames_sync + 1'b1;
            end else if (word_valid) begin
                frames_data <= frames_data + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ttc_cmd_tx.sv
// Bench for ttc_cmd_tx: slot-level reference model of the
// serial stream, per-cycle compare, and literal frame checks.
module tb_ttc_cmd_tx;
    import ttc_pkg::*;

    localparam int SI = 32;
    localparam int NI = 4;

    logic        clk160 = 1'b0;
    logic        rst;
    logic [15:0] data_in;
    logic        word_valid;
    logic        word_ready;
    logic        dataout;
    logic        frame_start;
`ifdef TTC_TX_STATS_EN
    logic [31:0] frames_data;
    logic [31:0] frames_sync;
`endif

    ttc_cmd_tx #(.SYNC_INTERVAL(SI), .INIT_SYNCS(NI)) dut (
        .clk160      (clk160),
        .rst         (rst),
        .data_in     (data_in),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .dataout     (dataout),
        .frame_start (frame_start)
`ifdef TTC_TX_STATS_EN
        ,
        .frames_data (frames_data),
        .frames_sync (frames_sync)
`endif
    );

    always #5 clk160 = ~clk160;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int          c;
    int          nonsync;
    int          mode;
    int          gap_pct;
    int          first_hs;
    logic [15:0] slot_frame[$];
    logic [15:0] src_q[$];
    // frames recovered from the DUT serial line
    logic [15:0] cap_q[$];
    logic [15:0] cap_sr;
    int          cap_n;
    logic [15:0] w[40];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, c);
        end
    endtask

    task automatic chk_cap(int k, logic [15:0] e);
        logic [15:0] v;
        v = (k < cap_q.size()) ? cap_q[k] : 16'hxxxx;
        chk($sformatf("frame[%0d]", k), {16'h0, v}, {16'h0, e});
    endtask

    task automatic do_reset(int n);
        rst        = 1'b1;
        word_valid = 1'b0;
        data_in    = 16'h0;
        #1;
        chk("ready_in_rst", {31'h0, word_ready}, 32'h0);
        for (int i = 0; i < n; i++) begin
            @(posedge clk160);
            #1;
            chk("dataout_rst", {31'h0, dataout}, 32'h0);
            chk("fstart_rst", {31'h0, frame_start}, 32'h0);
            chk("ready_rst", {31'h0, word_ready}, 32'h0);
        end
        rst      = 1'b0;
        c        = 0;
        nonsync  = 0;
        first_hs = -1;
        cap_n    = 0;
        slot_frame.delete();
        cap_q.delete();
    endtask

    // one clk160 cycle: drive, compare against model, advance model
    task automatic step();
        logic        v;
        logic [15:0] d;
        logic [15:0] f;
        logic        exp_do;
        logic        exp_fs;
        logic        exp_rdy;
        int          s;
        if (mode == 1) begin
            v = 1'b1;
            d = 16'hA5A5;
        end else begin
            v = (src_q.size() > 0) && (int'($urandom_range(99)) >= gap_pct);
            d = v ? src_q[0] : 16'($urandom);
        end
        word_valid = v;
        data_in    = d;
        #1;
        if (c == 0) begin
            exp_do = 1'b0;
            exp_fs = 1'b0;
        end else begin
            s      = (c - 1) / 16;
            f      = slot_frame[s];
            exp_do = f[15 - ((c - 1) % 16)];
            exp_fs = ((c - 1) % 16) == 0;
        end
        chk("dataout", {31'h0, dataout}, {31'h0, exp_do});
        chk("frame_start", {31'h0, frame_start}, {31'h0, exp_fs});
        exp_rdy = (c % 16 == 0) && (c / 16 >= NI) && (nonsync != SI - 1);
        chk("word_ready", {31'h0, word_ready}, {31'h0, exp_rdy});
        if (c % 16 == 0) begin
            if (c / 16 < NI || nonsync == SI - 1) begin
                f       = SYNC_PATTERN;
                nonsync = 0;
            end else if (v) begin
                f = d;
                nonsync++;
                if (mode == 0) void'(src_q.pop_front());
            end else begin
                f = NOOP_PATTERN;
                nonsync++;
            end
            slot_frame.push_back(f);
        end
        if (word_valid && word_ready && first_hs < 0) first_hs = c;
        if (frame_start) begin
            cap_sr = {15'h0, dataout};
            cap_n  = 1;
        end else if (cap_n > 0) begin
            cap_sr = {cap_sr[14:0], dataout};
            cap_n++;
        end
        if (cap_n == 16) begin
            cap_q.push_back(cap_sr);
            cap_n = 0;
        end
        c++;
        @(posedge clk160);
        #1;
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int   budget;
        mode    = 0;
        gap_pct = 0;

        // idle link: 4 syncs then NOOPs
        do_reset(3);
        run(16 * 7);
        for (int k = 0; k < 4; k++) chk_cap(k, 16'h817E);
        chk_cap(4, 16'h6969);
        chk_cap(5, 16'h6969);

        // word held valid from reset: first handshake at slot 4
        mode = 1;
        do_reset(3);
        run(16 * 7);
        chk("first_hs", first_hs, 64);
        chk_cap(3, 16'h817E);
        chk_cap(4, 16'hA5A5);
        chk_cap(5, 16'hA5A5);
        mode = 0;

        // 40-word stream, valid always high
        do_reset(2);
        for (int i = 0; i < 40; i++) begin
            w[i] = {8'(i), 8'($urandom)};
            src_q.push_back(w[i]);
        end
        run(16 * 47);
        chk_cap(4, w[0]);
        chk_cap(34, w[30]);
        chk_cap(35, 16'h817E);
        chk_cap(36, w[31]);
        chk_cap(44, w[39]);
        chk_cap(45, 16'h6969);
        chk("stream_drained", src_q.size(), 0);
`ifdef TTC_TX_STATS_EN
        chk("frames_data", frames_data, 32'd40);
        chk("frames_sync", frames_sync, 32'd5);
`endif

        // single word arriving mid-frame
        do_reset(2);
        run(101);
        src_q.push_back(16'h1234);
        run(16 * 4);
        chk("mid_hs", first_hs, 112);
        chk_cap(6, 16'h6969);
        chk_cap(7, 16'h1234);
        chk_cap(8, 16'h6969);

        // reset in the middle of a data frame
        do_reset(2);
        src_q.push_back(16'hBEEF);
        budget = 0;
        while (src_q.size() > 0 && budget < 200) begin
            step();
            budget++;
        end
        chk("beef_taken", src_q.size(), 0);
        run(9);
        do_reset(3);
        run(16 * 7);
        for (int k = 0; k < 4; k++) chk_cap(k, 16'h817E);
        chk_cap(4, 16'h6969);
        chk_cap(5, 16'h6969);

        // random words with random gaps across several sync slots
        do_reset(2);
        gap_pct = 40;
        for (int i = 0; i < 200; i++) src_q.push_back(16'($urandom));
        run(6000);
        chk("random_drained", src_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
